// File: rtl/hpu_pkg.sv
// Shared types and helpers for the hypervector processing blocks.
package hpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CLEAR
  } fsm_t;

  localparam int W_DEFAULT     = 32;
  localparam int WORDS_DEFAULT = 32;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count; pointers wrap naturally.
module sync_fifo
  import hpu_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   empty,
  output logic                   full,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sign_packer.sv
// Buffers counter sign words, frames them per hypervector and streams them out.
//   state | meaning
//   IDLE  | no hypervector in progress
//   FILL  | words of a hypervector being captured
//   CLEAR | hypervector complete, counter_clear asserted this cycle
module sign_packer
  import hpu_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int WORDS = WORDS_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] sign_in,
  output logic         full,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         counter_clear,
  output logic         busy,
  output logic         overflow
);

  localparam int IW = (WORDS > 1) ? clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  fsm_t                  state;
  logic [IW-1:0]         word_idx;
  logic                  fifo_empty;
  logic                  pop;
  logic                  accept;
  logic                  is_last;
  logic [W:0]            head;
  logic [clog2(DEPTH):0] fifo_count;

  assign pop     = !fifo_empty && m_ready;
  assign accept  = in_valid && (state != CLEAR) && (!full || pop);
  assign is_last = (word_idx == LAST_IDX);

  sync_fifo #(
    .W     (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata ({sign_in, is_last}),
    .rdata (head),
    .empty (fifo_empty),
    .full  (full),
    .count (fifo_count)
  );

  // Mask the head so m_data reads zero whenever nothing is valid.
  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? head[W:1] : '0;
  assign m_last  = m_valid & head[0];
  assign busy    = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      word_idx      <= '0;
      overflow      <= 1'b0;
      counter_clear <= 1'b0;
    end else begin
      counter_clear <= 1'b0;
      if (in_valid && !accept) overflow <= 1'b1;
      if (accept) word_idx <= is_last ? '0 : word_idx + 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_last) begin
              state         <= CLEAR;
              counter_clear <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (accept && is_last) begin
            state         <= CLEAR;
            counter_clear <= 1'b1;
          end
        end
        CLEAR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_packer.sv
// Directed bench for sign_packer with WORDS=4, DEPTH=8.
module tb_sign_packer;

  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] sign_in;
  logic         full;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         counter_clear;
  logic         busy;
  logic         overflow;

  int n_chk = 0;
  int n_err = 0;
  int n_clr = 0;
  logic [W:0] obs_q [$];
  logic [W:0] exp_q [$];

  sign_packer #(.W(W), .WORDS(WORDS), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .sign_in       (sign_in),
    .full          (full),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .counter_clear (counter_clear),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) obs_q.push_back({m_last, m_data});
      if (counter_clear) n_clr++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_word(input logic [W-1:0] d);
    in_valid = 1'b1;
    sign_in  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input logic last, input logic [W-1:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    sign_in  = '0;
    m_ready  = 1'b0;
    idle(2);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    n_clr = 0;
  endtask

  task automatic drain_and_compare(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (obs_q.size() >= exp_q.size() && !m_valid) break;
      tick();
    end
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic fill_eight(input logic [W-1:0] base);
    for (int i = 0; i < 4; i++) push_word(base + W'(i));
    idle(4);
    for (int i = 4; i < 8; i++) push_word(base + W'(i));
  endtask

  initial begin
    do_reset();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_clear", 64'(counter_clear), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // Single hypervector streamed straight through.
    m_ready  = 1'b1;
    in_valid = 1'b1;
    sign_in  = 32'hA5A5_A5A5;
    tick();
    check("t1_lat_valid", 64'(m_valid), 64'd1);
    check("t1_lat_data", 64'(m_data), 64'hA5A5_A5A5);
    sign_in = 32'h1;
    tick();
    sign_in = 32'h2;
    tick();
    sign_in = 32'hFFFF_FFFF;
    tick();
    check("t1_clear_hi", 64'(counter_clear), 64'd1);
    check("t1_last_hi", 64'(m_last), 64'd1);
    in_valid = 1'b0;
    tick();
    check("t1_clear_lo", 64'(counter_clear), 64'd0);
    check("t1_busy_lo", 64'(busy), 64'd0);
    check("t1_overflow", 64'(overflow), 64'd0);
    expect_word(1'b0, 32'hA5A5_A5A5);
    expect_word(1'b0, 32'h1);
    expect_word(1'b0, 32'h2);
    expect_word(1'b1, 32'hFFFF_FFFF);
    drain_and_compare("t1");
    check("t1_clr_pulses", 64'(n_clr), 64'd1);

    // Fill to DEPTH with no readiness, then overrun.
    do_reset();
    fill_eight(32'h10);
    check("t2_full", 64'(full), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    idle(4);
    check("t2_ovf_before", 64'(overflow), 64'd0);
    push_word(32'h99);
    check("t2_ovf_after", 64'(overflow), 64'd1);
    check("t2_full_kept", 64'(full), 64'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_word(i == 3 || i == 7, 32'h10 + W'(i));
    drain_and_compare("t2");
    check("t2_clr_pulses", 64'(n_clr), 64'd2);
    check("t2_ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with simultaneous pop and push.
    do_reset();
    fill_eight(32'h10);
    idle(4);
    m_ready = 1'b1;
    push_word(32'h20);
    check("t3_full_kept", 64'(full), 64'd1);
    check("t3_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 7; i++) expect_word(i == 2 || i == 6, 32'h11 + W'(i));
    expect_word(1'b0, 32'h20);
    exp_q.push_front({1'b0, 32'h10});
    drain_and_compare("t3");

    // Input during the CLEAR cycle is dropped.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h40 + W'(i));
    check("t4_in_clear", 64'(counter_clear), 64'd1);
    push_word(32'hDEAD);
    check("t4_overflow", 64'(overflow), 64'd1);
    idle(3);
    for (int i = 0; i < 4; i++) push_word(32'h50 + W'(i));
    for (int i = 0; i < 4; i++) expect_word(i == 3, 32'h40 + W'(i));
    for (int i = 0; i < 4; i++) expect_word(i == 3, 32'h50 + W'(i));
    drain_and_compare("t4");

    // Two hypervectors back to back.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h60 + W'(i));
    idle(3);
    for (int i = 0; i < 4; i++) push_word(32'h70 + W'(i));
    for (int i = 0; i < 4; i++) expect_word(i == 3, 32'h60 + W'(i));
    for (int i = 0; i < 4; i++) expect_word(i == 3, 32'h70 + W'(i));
    drain_and_compare("t5");
    check("t5_clr_pulses", 64'(n_clr), 64'd2);
    check("t5_overflow", 64'(overflow), 64'd0);

    // Reset in the middle of a hypervector.
    do_reset();
    push_word(32'h80);
    push_word(32'h81);
    check("t6_pre_valid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", 64'(m_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_clear", 64'(counter_clear), 64'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h90 + W'(i));
    for (int i = 0; i < 4; i++) expect_word(i == 3, 32'h90 + W'(i));
    drain_and_compare("t6");
    check("t6_clr_pulses", 64'(n_clr), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
